// File: rtl/apb_pkg.sv
// Shared APB definitions: master FSM encoding, default slave window and request payload.
package apb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] SLV_BASE_DEF  = 32'h0000_0200;
    localparam logic [ADDR_W-1:0] SLV_LIMIT_DEF = 32'h0000_11FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state watchdog: counts stalled ACCESS cycles and flags the terminal count.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Terminal count is one below TIMEOUT so the abort lands on the TIMEOUT-th stalled cycle.
    assign expired_c = (TIMEOUT != 32'd0) && (cnt_q == CNT_W'(TIMEOUT - 32'd1));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB3 master sequencer: one CPU load/store at a time, window decode, wait states,
// slave errors and a watchdog abort, with a one-cycle response pulse.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] SLV_BASE  = SLV_BASE_DEF,
    parameter logic [ADDR_W-1:0] SLV_LIMIT = SLV_LIMIT_DEF,
    parameter int unsigned       TIMEOUT   = 255,
    parameter int unsigned       CNT_W     = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t        state_q, state_d;
    apb_req_t          bus_q, bus_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              hit_c;
    logic              cnt_clr_c;
    logic              cnt_en_c;
    logic              expired_c;

    assign hit_c = (req_addr >= SLV_BASE) && (req_addr <= SLV_LIMIT) &&
                   (req_addr[1:0] == 2'b00);

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .clr       (cnt_clr_c),
        .en        (cnt_en_c),
        .expired_c (expired_c)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Bus payload holds between transfers; the response fields only live for one cycle.
    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        cnt_clr_c   = 1'b0;
        cnt_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (hit_c) begin
                        state_d     = SETUP;
                        psel_d      = 1'b1;
                        penable_d   = 1'b0;
                        bus_d.addr  = req_addr;
                        bus_d.write = req_write;
                        bus_d.wdata = req_wdata;
                        bus_d.strb  = req_write ? req_strb : '0;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_clr_c = 1'b1;
            end
            ACCESS: begin
                // A ready slave wins over a watchdog expiring on the same edge.
                if (PREADY) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (!bus_q.write && !PSLVERR) ? PRDATA : '0;
                end else begin
                    cnt_en_c = 1'b1;
                    if (expired_c) begin
                        state_d     = IDLE;
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    assign PADDR     = bus_q.addr;
    assign PWRITE    = bus_q.write;
    assign PWDATA    = bus_q.wdata;
    assign PSTRB     = bus_q.strb;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
APB3 master sequencer between the RV32I pipeline's data-memory port and the peripheral APB bus. It accepts one CPU load/store request at a time and decodes it against the slave window. It drives the SETUP/ACCESS protocol, handles PREADY wait states and PSLVERR, and returns a single-cycle response. A watchdog aborts transfers stalled by a hung slave, and unmapped or misaligned addresses are rejected without any bus activity.

Parameters:
SLV_BASE, 32'h0000_0200, first byte address of the slave window (inclusive).
SLV_LIMIT, 32'h0000_11FF, last byte address of the slave window (inclusive).
TIMEOUT, 255, maximum ACCESS cycles with PREADY low before abort; 0 disables the watchdog.
CNT_W, 8, watchdog counter width; must satisfy 2**CNT_W > TIMEOUT.

Ports:
PCLK  in  1  system clock, rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  1  CPU request strobe
req_ready  out  1  high in IDLE only; request accepted on req_valid&&req_ready
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_wdata  in  32  store data
req_strb  in  4  store byte enables
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  load data; 0 on error or store
rsp_err  out  1  PSLVERR, decode error, or timeout
busy  out  1  state != IDLE
PADDR  out  32  APB address
PSEL  out  1  slave select
PENABLE  out  1  ACCESS phase
PWRITE  out  1  direction
PWDATA  out  32  write data
PSTRB  out  4  write strobes; 0 on reads
PRDATA  in  32  read data
PREADY  in  1  slave ready
PSLVERR  in  1  slave error

Behaviour:
- Reset: asynchronous, active-low. State goes to IDLE and every output is 0, except req_ready=1. Assertion mid-transfer drops PSEL/PENABLE immediately and no response is issued. The counter clears.
- All outputs are registered except req_ready and busy, which decode the state directly.
- FSM states: IDLE, SETUP, ACCESS, ERR.
- IDLE, accept edge: latch addr/write/wdata/strb.
  - Address hit (SLV_BASE <= addr <= SLV_LIMIT) and addr[1:0]==0: next state SETUP; PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven.
  - Otherwise: next state ERR; no PSEL.
- SETUP: unconditional move to ACCESS; PENABLE=1; counter cleared.
- ACCESS, PREADY=1 at the edge:
  - PSEL=0, PENABLE=0, state IDLE.
  - Following cycle: rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for a read with PSLVERR=0, else 0.
- ACCESS, PREADY=0: counter increments.
  - If TIMEOUT!=0 and counter==TIMEOUT-1: abort. PSEL and PENABLE drop, state IDLE, response rsp_err=1, rsp_rdata=0.
  - A PREADY=1 arriving on the abort edge completes normally; the transfer is not reported as a timeout.
- ERR: single cycle, back to IDLE; same response timing as a completed transfer, with rsp_err=1 and rsp_rdata=0.
- Stability: PADDR/PWRITE/PWDATA/PSTRB stay constant from SETUP through the last ACCESS cycle. They hold their last values after completion; PSTRB=0 whenever PWRITE=0.
- Latency: zero-wait read = accept edge T, SETUP T+1, ACCESS T+2, rsp_valid during T+3. Each wait state adds 1 cycle.
- Back-to-back: rsp_valid and req_ready are both high in the same IDLE cycle, so a new request may be accepted there. Minimum spacing is 3 cycles per transfer.
- req_valid while busy is ignored (req_ready=0); the CPU must hold it.
- Boundaries: addr 0x1FF and 0x1200 decode-error; 0x200 and 0x11FC hit; 0x11FD hits the window but is misaligned → error.

Decomposition:
- Shared package apb_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, ERR=2'd3) and the default slave window base/limit constants, so the master and the system decoder use one definition.
- Natural sub-module: apb_timeout_cnt (clear, enable, terminal-count compare against TIMEOUT, disable when 0).
- The range compare stays inline.

Test Plan:
1. Read 0x0000_0400, PREADY=1 in first ACCESS, PRDATA=0xDEADBEEF → PSEL at T+1, PENABLE at T+2, rsp_valid at T+3 with rdata=0xDEADBEEF, err=0.
2. Write 0x0000_0200, wdata=0x12345678, strb=4'b0011, PREADY low for 3 cycles → PADDR/PWDATA/PSTRB stable for all 5 bus cycles, rsp_valid at T+6, err=0.
3. Reads at 0x0000_01FF and 0x0000_1200, plus a read at 0x0000_0202 → PSEL never asserts, rsp_valid at T+2 with err=1, rdata=0.
4. PREADY held low, TIMEOUT=255 → abort after 255 ACCESS cycles, PSEL/PENABLE drop, rsp_err=1; the next request is accepted normally.
5. PSLVERR=1 with PREADY=1 on a read → rsp_err=1, rsp_rdata=0. Then a second request accepted in the rsp_valid cycle → PSEL at the following edge.
6. PRESETn pulsed low during ACCESS → PSEL, PENABLE, and rsp_valid go 0 asynchronously, busy=0, no response after release.
